// File: rtl/simt_op_sched.sv
// ============================================================================
// simt_op_sched
// ----------------------------------------------------------------------------
// Funnels SIMT-stack update operations from the two decode lanes (ID1, ID2)
// and the EX branch-resolution port onto the stack's single valid/ready
// operation port.
//
// Decode ops are queued in a small FIFO. The most recent EX branch outcome
// sits in a dedicated one-entry slot. The EX slot normally wins arbitration.
// A starvation counter forces the FIFO head out after STARVE_MAX back-to-back
// EX grants. Once an op is presented, it is locked in until the stack
// accepts it.
//
// Each warp has a pending-op count. It drives a registered per-warp fetch
// stall, which also asserts for every warp when the FIFO is nearly full.
// Dropped ops (FIFO full, EX slot busy) set a sticky overflow error.
//
// Parameters
//   DEPTH       decode-op FIFO entries (power of 2, >= 2)
//   STARVE_MAX  EX grants allowed in a row while the FIFO waits
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   Valid/Op/WarpID/PCplus4_ID1   decode lane 1 op
//   Valid/Op/WarpID/PCplus4_ID2   decode lane 2 op
//   CondBr/WarpID/CondOutcome_Ex  branch outcome from EX
//   OpValid/OpReady               handshake to the SIMT stack
//   OpType/OpWarp/OpPC/OpMask     presented op fields
//   Stall_SCH_IF                  per-warp fetch stall (registered)
//   Overflow_Err_SCH              sticky protocol-violation flag
//
// Optional build macro
//   SIMT_SCHED_STATS_EN  adds ExGrants_SCH, IdGrants_SCH and StallCycles_SCH
//                        statistics counters (16 bit each)
// ============================================================================
module simt_op_sched #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        Valid_ID1_SCH,
    input  logic [2:0]  Op_ID1_SCH,
    input  logic [2:0]  WarpID_ID1_SCH,
    input  logic [9:0]  PCplus4_ID1_SCH,

    input  logic        Valid_ID2_SCH,
    input  logic [2:0]  Op_ID2_SCH,
    input  logic [2:0]  WarpID_ID2_SCH,
    input  logic [9:0]  PCplus4_ID2_SCH,

    input  logic        CondBr_Ex_SCH,
    input  logic [2:0]  WarpID_Ex_SCH,
    input  logic [7:0]  CondOutcome_Ex_SCH,

    output logic        OpValid_SCH_SIMT,
    input  logic        OpReady_SIMT_SCH,
    output logic [2:0]  OpType_SCH_SIMT,
    output logic [2:0]  OpWarp_SCH_SIMT,
    output logic [9:0]  OpPC_SCH_SIMT,
    output logic [7:0]  OpMask_SCH_SIMT,

    output logic [7:0]  Stall_SCH_IF,
    output logic        Overflow_Err_SCH
`ifdef SIMT_SCHED_STATS_EN
    ,
    output logic [15:0] ExGrants_SCH,
    output logic [15:0] IdGrants_SCH,
    output logic [15:0] StallCycles_SCH
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int SCNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [SCNT_W-1:0] STARVE_MAX_C = SCNT_W'(STARVE_MAX);

    localparam logic [2:0] OP_BROUT = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        fifo_op   [DEPTH];
    logic [2:0]        fifo_warp [DEPTH];
    logic [9:0]        fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              ex_valid;
    logic [2:0]        ex_warp;
    logic [7:0]        ex_mask;

    logic [SCNT_W-1:0] starve_cnt;
    logic              lock_q;
    logic              lock_ex_q;
    logic [2:0]        pend_q    [8];
    logic [7:0]        stall_q;
    logic              overflow_q;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    logic              fifo_empty;
    logic              op_valid;
    logic              sel_ex;
    logic              grant;
    logic              ex_grant;
    logic              fifo_grant;
    logic [2:0]        sel_warp;

    logic              id1_legal;
    logic              id2_legal;
    logic              id1_acc;
    logic              id2_acc;
    logic              ex_acc;
    logic              overflow_evt;
    logic [CNT_W-1:0]  free_slots;
    logic [CNT_W-1:0]  cnt_next;
    logic              almost_full_next;
    logic [PTR_W-1:0]  id2_ptr;

    logic [2:0]        pend_next [8];
    logic [7:0]        stall_next;

    // Op codes 1..5 are the only legal decode ops; 0, 6 and 7 are ignored.
    assign id1_legal = Valid_ID1_SCH && (Op_ID1_SCH >= 3'd1) && (Op_ID1_SCH <= 3'd5);
    assign id2_legal = Valid_ID2_SCH && (Op_ID2_SCH >= 3'd1) && (Op_ID2_SCH <= 3'd5);

    // ------------------------------------------------------------------
    // Arbitration.
    // The EX slot wins unless the FIFO has been passed over STARVE_MAX
    // times in a row. While an op is presented and not yet accepted, the
    // earlier choice is replayed from lock_ex_q. A newly arriving EX
    // outcome therefore cannot displace a FIFO head that the stack is
    // already looking at. The locked source cannot vanish, because
    // sources are popped only on their own grant.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        op_valid   = ex_valid || !fifo_empty;
        if (lock_q) begin
            sel_ex = lock_ex_q;
        end else begin
            sel_ex = ex_valid && !(!fifo_empty && (starve_cnt == STARVE_MAX_C));
        end
        grant      = op_valid && OpReady_SIMT_SCH;
        ex_grant   = grant && sel_ex;
        fifo_grant = grant && !sel_ex;
        sel_warp   = sel_ex ? ex_warp : fifo_warp[rd_ptr];
    end

    // ------------------------------------------------------------------
    // Presented op fields.
    // Everything is forced to zero while nothing is valid, so the port
    // reads all-zero straight after reset.
    // ------------------------------------------------------------------
    always_comb begin
        OpValid_SCH_SIMT = op_valid;
        OpType_SCH_SIMT  = 3'd0;
        OpWarp_SCH_SIMT  = 3'd0;
        OpPC_SCH_SIMT    = 10'd0;
        OpMask_SCH_SIMT  = 8'd0;
        if (op_valid) begin
            OpWarp_SCH_SIMT = sel_warp;
            if (sel_ex) begin
                OpType_SCH_SIMT = OP_BROUT;
                OpMask_SCH_SIMT = ex_mask;
            end else begin
                OpType_SCH_SIMT = fifo_op[rd_ptr];
                OpPC_SCH_SIMT   = fifo_pc[rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Enqueue admission.
    // Free space is counted after crediting a same-cycle pop. ID1 takes
    // the first free entry. ID2 takes the next one. If ID1 was illegal,
    // ID2 moves up into the first entry. The EX slot can be refilled in
    // the cycle its current content is granted.
    // ------------------------------------------------------------------
    always_comb begin
        free_slots   = DEPTH_C - fifo_cnt + CNT_W'(fifo_grant);
        id1_acc      = id1_legal && (free_slots != '0);
        if (id1_acc) begin
            id2_acc = id2_legal && (free_slots >= CNT_W'(2));
        end else begin
            id2_acc = id2_legal && (free_slots != '0);
        end
        ex_acc       = CondBr_Ex_SCH && (!ex_valid || ex_grant);
        overflow_evt = (id1_legal && !id1_acc) ||
                       (id2_legal && !id2_acc) ||
                       (CondBr_Ex_SCH && !ex_acc);
        id2_ptr      = wr_ptr + PTR_W'(id1_acc);
        cnt_next     = fifo_cnt - CNT_W'(fifo_grant)
                     + CNT_W'(id1_acc) + CNT_W'(id2_acc);
        almost_full_next = (DEPTH_C - cnt_next) < CNT_W'(2);
    end

    // ------------------------------------------------------------------
    // Per-warp pending counts and the stall vector for the next cycle.
    // A warp can see up to three enqueues and one grant in one cycle.
    // 3-bit modular arithmetic nets these out correctly as long as the
    // true count stays in range.
    // ------------------------------------------------------------------
    always_comb begin
        stall_next = 8'd0;
        for (int w = 0; w < 8; w++) begin
            pend_next[w] = pend_q[w]
                         + 3'(id1_acc  && (WarpID_ID1_SCH == 3'(w)))
                         + 3'(id2_acc  && (WarpID_ID2_SCH == 3'(w)))
                         + 3'(ex_acc   && (WarpID_Ex_SCH  == 3'(w)))
                         - 3'(grant    && (sel_warp       == 3'(w)));
            stall_next[w] = (pend_next[w] != 3'd0) || almost_full_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. Entries need no reset; occupancy is tracked by the
    // pointers and the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (id1_acc) begin
            fifo_op[wr_ptr]   <= Op_ID1_SCH;
            fifo_warp[wr_ptr] <= WarpID_ID1_SCH;
            fifo_pc[wr_ptr]   <= PCplus4_ID1_SCH;
        end
        if (id2_acc) begin
            fifo_op[id2_ptr]   <= Op_ID2_SCH;
            fifo_warp[id2_ptr] <= WarpID_ID2_SCH;
            fifo_pc[id2_ptr]   <= PCplus4_ID2_SCH;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy. DEPTH is a power of two, so the
    // pointers wrap on their own.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_grant) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            wr_ptr   <= wr_ptr + PTR_W'(id1_acc) + PTR_W'(id2_acc);
            fifo_cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // EX outcome slot. It holds a single outcome. A grant and a refill
    // in the same cycle leave it occupied with the new outcome.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_warp  <= 3'd0;
            ex_mask  <= 8'd0;
        end else begin
            if (ex_acc) begin
                ex_valid <= 1'b1;
                ex_warp  <= WarpID_Ex_SCH;
                ex_mask  <= CondOutcome_Ex_SCH;
            end else if (ex_grant) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter and presentation lock.
    // The counter tracks EX grants taken while decode ops were waiting.
    // Any FIFO grant, or an empty FIFO, clears it. The lock remembers
    // which source is on the port while the stack holds off.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            lock_q     <= 1'b0;
            lock_ex_q  <= 1'b0;
        end else begin
            if (fifo_grant || fifo_empty) begin
                starve_cnt <= '0;
            end else if (ex_grant && (starve_cnt != STARVE_MAX_C)) begin
                starve_cnt <= starve_cnt + SCNT_W'(1);
            end
            lock_q    <= op_valid && !OpReady_SIMT_SCH;
            lock_ex_q <= sel_ex;
        end
    end

    // ------------------------------------------------------------------
    // Pending counts, the registered stall vector and the sticky
    // overflow flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 8; w++) begin
                pend_q[w] <= 3'd0;
            end
            stall_q    <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            for (int w = 0; w < 8; w++) begin
                pend_q[w] <= pend_next[w];
            end
            stall_q <= stall_next;
            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign Stall_SCH_IF     = stall_q;
    assign Overflow_Err_SCH = overflow_q;

`ifdef SIMT_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Statistics. The grant counters stick at all-ones instead of
    // wrapping. StallCycles counts cycles in which the registered stall
    // vector has any bit set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ExGrants_SCH    <= 16'd0;
            IdGrants_SCH    <= 16'd0;
            StallCycles_SCH <= 16'd0;
        end else begin
            if (ex_grant && (ExGrants_SCH != 16'hFFFF)) begin
                ExGrants_SCH <= ExGrants_SCH + 16'd1;
            end
            if (fifo_grant && (IdGrants_SCH != 16'hFFFF)) begin
                IdGrants_SCH <= IdGrants_SCH + 16'd1;
            end
            if (|stall_q) begin
                StallCycles_SCH <= StallCycles_SCH + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simt_op_sched.sv
// ============================================================================
// tb_simt_op_sched
// ----------------------------------------------------------------------------
// Directed testbench for simt_op_sched with DEPTH=4 and STARVE_MAX=3.
// Inputs change 1 ns after each rising clock edge and outputs are checked
// there too, so every check sees the state left by the previous edge.
// ============================================================================
module tb_simt_op_sched;

    logic        clk;
    logic        rst;
    logic        v1;
    logic [2:0]  op1;
    logic [2:0]  w1;
    logic [9:0]  pc1;
    logic        v2;
    logic [2:0]  op2;
    logic [2:0]  w2;
    logic [9:0]  pc2;
    logic        ex_v;
    logic [2:0]  ex_w;
    logic [7:0]  ex_m;
    logic        op_ready;

    logic        op_valid;
    logic [2:0]  op_type;
    logic [2:0]  op_warp;
    logic [9:0]  op_pc;
    logic [7:0]  op_mask;
    logic [7:0]  stall;
    logic        ovf;

`ifdef SIMT_SCHED_STATS_EN
    logic [15:0] ex_grants;
    logic [15:0] id_grants;
    logic [15:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    simt_op_sched #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .Valid_ID1_SCH      (v1),
        .Op_ID1_SCH         (op1),
        .WarpID_ID1_SCH     (w1),
        .PCplus4_ID1_SCH    (pc1),
        .Valid_ID2_SCH      (v2),
        .Op_ID2_SCH         (op2),
        .WarpID_ID2_SCH     (w2),
        .PCplus4_ID2_SCH    (pc2),
        .CondBr_Ex_SCH      (ex_v),
        .WarpID_Ex_SCH      (ex_w),
        .CondOutcome_Ex_SCH (ex_m),
        .OpValid_SCH_SIMT   (op_valid),
        .OpReady_SIMT_SCH   (op_ready),
        .OpType_SCH_SIMT    (op_type),
        .OpWarp_SCH_SIMT    (op_warp),
        .OpPC_SCH_SIMT      (op_pc),
        .OpMask_SCH_SIMT    (op_mask),
        .Stall_SCH_IF       (stall),
        .Overflow_Err_SCH   (ovf)
`ifdef SIMT_SCHED_STATS_EN
        ,
        .ExGrants_SCH       (ex_grants),
        .IdGrants_SCH       (id_grants),
        .StallCycles_SCH    (stall_cycles)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Check every field of the presented op against the expected values.
    task automatic checkOp(input string tag, input logic v, input logic [2:0] t,
                           input logic [2:0] w, input logic [9:0] pc,
                           input logic [7:0] m);
        checkOutput({tag, ".valid"}, 32'(op_valid), 32'(v));
        checkOutput({tag, ".type"},  32'(op_type),  32'(t));
        checkOutput({tag, ".warp"},  32'(op_warp),  32'(w));
        checkOutput({tag, ".pc"},    32'(op_pc),    32'(pc));
        checkOutput({tag, ".mask"},  32'(op_mask),  32'(m));
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of lane/EX inputs, clock it in, then drop the valids.
    task automatic applyStimulus(input logic a_v1, input logic [2:0] a_op1,
                                 input logic [2:0] a_w1, input logic [9:0] a_pc1,
                                 input logic a_v2, input logic [2:0] a_op2,
                                 input logic [2:0] a_w2, input logic [9:0] a_pc2,
                                 input logic a_ex, input logic [2:0] a_exw,
                                 input logic [7:0] a_exm);
        v1 = a_v1;  op1 = a_op1;  w1 = a_w1;  pc1 = a_pc1;
        v2 = a_v2;  op2 = a_op2;  w2 = a_w2;  pc2 = a_pc2;
        ex_v = a_ex; ex_w = a_exw; ex_m = a_exm;
        tick();
        v1 = 1'b0; v2 = 1'b0; ex_v = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold reset across one clock edge.
    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        v1 = 0; op1 = 0; w1 = 0; pc1 = 0;
        v2 = 0; op2 = 0; w2 = 0; pc2 = 0;
        ex_v = 0; ex_w = 0; ex_m = 0;
        op_ready = 1'b0;
        tick();
        doReset();

        // Reset state: all outputs zero.
        checkOp("reset", 0, 0, 0, 10'h000, 8'h00);
        checkOutput("reset.stall", 32'(stall), 32'h00);
        checkOutput("reset.ovf",   32'(ovf),   32'h0);

        // Single Call on warp 2, passed straight through.
        op_ready = 1'b1;
        applyStimulus(1, 3'd3, 3'd2, 10'h040, 0, 0, 0, 0, 0, 0, 0);
        checkOp("call", 1, 3'd3, 3'd2, 10'h040, 8'h00);
        checkOutput("call.stall", 32'(stall), 32'h04);
        idle();
        checkOutput("call.gone",   32'(op_valid), 32'h0);
        checkOutput("call.unstal", 32'(stall),    32'h00);

        // Dual issue: ID1 Jump w1, then ID2 Ret w5.
        applyStimulus(1, 3'd5, 3'd1, 10'h010, 1, 3'd4, 3'd5, 10'h020, 0, 0, 0);
        checkOp("dual0", 1, 3'd5, 3'd1, 10'h010, 8'h00);
        checkOutput("dual0.stall", 32'(stall), 32'h22);
        idle();
        checkOp("dual1", 1, 3'd4, 3'd5, 10'h020, 8'h00);
        checkOutput("dual1.stall", 32'(stall), 32'h20);
        idle();
        checkOutput("dual.empty", 32'(op_valid), 32'h0);

        // Backpressure: the FIFO head stays locked on the port even after an EX outcome arrives.
        op_ready = 1'b0;
        applyStimulus(1, 3'd1, 3'd3, 10'h100, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOp("hold", 1, 3'd1, 3'd3, 10'h100, 8'h00);
            idle();
        end
        checkOutput("hold.stall", 32'(stall), 32'h08);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 8'h3C);
        checkOp("lock", 1, 3'd1, 3'd3, 10'h100, 8'h00);
        checkOutput("lock.stall", 32'(stall), 32'h18);
        op_ready = 1'b1;
        idle();
        checkOp("lock.ex", 1, 3'd6, 3'd4, 10'h000, 8'h3C);
        checkOutput("lock.ex.stall", 32'(stall), 32'h10);
        idle();
        checkOutput("lock.empty", 32'(op_valid), 32'h0);

        // Starvation: three EX grants, then the forced FIFO head, then EX again.
        op_ready = 1'b0;
        applyStimulus(1, 3'd2, 3'd6, 10'h200, 0, 0, 0, 0, 1, 3'd7, 8'h01);
        checkOp("starve.ex1", 1, 3'd6, 3'd7, 10'h000, 8'h01);
        checkOutput("starve.stall", 32'(stall), 32'hC0);
        op_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7, 8'h02);
        checkOp("starve.ex2", 1, 3'd6, 3'd7, 10'h000, 8'h02);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7, 8'h03);
        checkOp("starve.ex3", 1, 3'd6, 3'd7, 10'h000, 8'h03);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7, 8'h04);
        checkOp("starve.fifo", 1, 3'd2, 3'd6, 10'h200, 8'h00);
        idle();
        checkOp("starve.resume", 1, 3'd6, 3'd7, 10'h000, 8'h04);
        idle();
        checkOutput("starve.empty", 32'(op_valid), 32'h0);
        checkOutput("starve.stall0", 32'(stall), 32'h00);
        checkOutput("starve.ovf", 32'(ovf), 32'h0);

        // Fill to DEPTH-1 (all warps stall), send illegal ops, then overflow on a dual write.
        op_ready = 1'b0;
        applyStimulus(1, 3'd1, 3'd0, 10'h004, 1, 3'd1, 3'd1, 10'h008, 0, 0, 0);
        checkOutput("fill2.stall", 32'(stall), 32'h03);
        applyStimulus(1, 3'd2, 3'd2, 10'h00C, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fill3.stall", 32'(stall), 32'hFF);
        checkOutput("fill3.ovf",   32'(ovf),   32'h0);
        applyStimulus(1, 3'd0, 3'd5, 10'h0AA, 1, 3'd7, 3'd6, 10'h0BB, 0, 0, 0);
        checkOutput("illegal.ovf", 32'(ovf), 32'h0);
        applyStimulus(1, 3'd3, 3'd3, 10'h010, 1, 3'd4, 3'd4, 10'h014, 0, 0, 0);
        checkOutput("ovf.set", 32'(ovf), 32'h1);
        checkOp("ovf.head", 1, 3'd1, 3'd0, 10'h004, 8'h00);
        op_ready = 1'b1;
        idle();
        checkOp("drain1", 1, 3'd1, 3'd1, 10'h008, 8'h00);
        checkOutput("drain1.stall", 32'(stall), 32'hFF);
        idle();
        checkOp("drain2", 1, 3'd2, 3'd2, 10'h00C, 8'h00);
        checkOutput("drain2.stall", 32'(stall), 32'h0C);
        idle();
        checkOp("drain3", 1, 3'd3, 3'd3, 10'h010, 8'h00);
        checkOutput("drain3.stall", 32'(stall), 32'h08);
        idle();
        checkOutput("drain.empty", 32'(op_valid), 32'h0);
        checkOutput("drain.stall", 32'(stall), 32'h00);
        checkOutput("ovf.sticky", 32'(ovf), 32'h1);

        // Reset clears the sticky error.
        doReset();
        checkOutput("rst.ovf", 32'(ovf), 32'h0);

        // EX slot busy while the stack stalls: the second outcome is dropped.
        op_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd5, 8'h5A);
        checkOp("exbusy1", 1, 3'd6, 3'd5, 10'h000, 8'h5A);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6, 8'hA5);
        checkOp("exbusy2", 1, 3'd6, 3'd5, 10'h000, 8'h5A);
        checkOutput("exbusy.ovf",   32'(ovf),   32'h1);
        checkOutput("exbusy.stall", 32'(stall), 32'h20);
        op_ready = 1'b1;
        idle();
        checkOutput("exbusy.empty", 32'(op_valid), 32'h0);
        checkOutput("exbusy.stall0", 32'(stall), 32'h00);
        checkOutput("exbusy.ovf1", 32'(ovf), 32'h1);

        // Reset while an op is waiting: it is discarded, not replayed.
        op_ready = 1'b0;
        applyStimulus(1, 3'd5, 3'd0, 10'h3FC, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst.pre", 32'(op_valid), 32'h1);
        doReset();
        checkOp("midrst.post", 0, 0, 0, 10'h000, 8'h00);
        checkOutput("midrst.stall", 32'(stall), 32'h00);
        checkOutput("midrst.ovf", 32'(ovf), 32'h0);
        op_ready = 1'b1;
        idle();
        checkOutput("midrst.noreplay", 32'(op_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
